// File: rtl/ecc_engine_ctrl.sv
// SECDED (extended Hamming) engine: encode, decode or full channel on 8/16-bit codewords.
// Operands are captured on CTRL_ready; the result, error count and a done pulse are registered.
module ecc_engine_ctrl #(
    parameter int unsigned AMBA_WORD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    input  logic                 CTRL_ready,
    output logic [AMBA_WORD-1:0] data_out,
    output logic [1:0]           num_of_errors,
    output logic                 operation_done,
    output logic                 busy
);

    localparam int unsigned CW_W  = 16;
    localparam int unsigned DW_W  = 11;
    localparam int unsigned SYN_W = 4;

    localparam logic [1:0] OP_ENC  = 2'd0;
    localparam logic [1:0] OP_DEC  = 2'd1;
    localparam logic [1:0] OP_FULL = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC,
        S_NOISE,
        S_SYND,
        S_CORR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    logic              wide_q;
    logic [DW_W-1:0]   data_q;
    logic [CW_W-1:0]   noise_q;
    logic [CW_W-1:0]   cw_q;
    logic [SYN_W-1:0]  syn_q;
    logic              par_q;
    logic              start;
    logic [CW_W-1:0]   enc_cw;
    logic [CW_W-1:0]   cap_mask;
    logic [AMBA_WORD-1:0] res_d;
    logic [1:0]        err_d;
    logic              unused_bits;

    assign unused_bits = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:1]};

    // Data bit j sits at the j-th non-power-of-two position; 8-bit codewords stop at position 7.
    function automatic logic [CW_W-1:0] encode(input logic [DW_W-1:0] d, input logic wide);
        logic [CW_W-1:0] cw;
        logic [3:0]      j;
        logic            p;
        cw = '0;
        j  = '0;
        for (int i = 1; i < 16; i++) begin
            if (((i & (i - 1)) != 0) && (wide || (i < 8))) begin
                cw[4'(i)] = d[j];
                j         = j + 4'd1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int i = 1; i < 16; i++) begin
                if (((i >> k) & 1) != 0) p = p ^ cw[4'(i)];
            end
            cw[4'(1 << k)] = p;
        end
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    function automatic logic [DW_W-1:0] extract(input logic [CW_W-1:0] cw, input logic wide);
        logic [DW_W-1:0] d;
        logic [3:0]      j;
        d = '0;
        j = '0;
        for (int i = 1; i < 16; i++) begin
            if (((i & (i - 1)) != 0) && (wide || (i < 8))) begin
                d[j] = cw[4'(i)];
                j    = j + 4'd1;
            end
        end
        return d;
    endfunction

    function automatic logic [SYN_W:0] syndrome(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int i = 1; i < 16; i++) begin
            if (cw[4'(i)]) s = s ^ 4'(i);
        end
        return {s, ^cw};
    endfunction

    assign start    = CTRL_ready && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign cap_mask = CODEWORD_WIDTH[0] ? 16'hFFFF : 16'h00FF;
    assign enc_cw   = encode(data_q, wide_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; DONE accepts a new op directly for back-to-back operation
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (CTRL_ready) begin
                    case (CTRL[1:0])
                        OP_ENC, OP_FULL: state_d = S_ENC;
                        OP_DEC:          state_d = S_SYND;
                        default:         state_d = S_DONE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ENC:   state_d = (op_q == OP_FULL) ? S_NOISE : S_DONE;
            S_NOISE: state_d = S_SYND;
            S_SYND:  state_d = S_CORR;
            S_CORR:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result computation; reserved ops reach DONE from IDLE/DONE and so report zero
    always_comb begin
        logic [CW_W-1:0] fixed;
        res_d = '0;
        err_d = 2'd0;
        fixed = cw_q;
        case (state_q)
            S_ENC: begin
                if (op_q == OP_ENC) res_d = AMBA_WORD'(enc_cw);
            end
            S_CORR: begin
                if (par_q) begin
                    fixed[syn_q] = ~fixed[syn_q];
                    err_d        = 2'd1;
                end else if (syn_q != '0) begin
                    err_d = 2'd2;
                end
                res_d = AMBA_WORD'(extract(fixed, wide_q));
            end
            default: ;
        endcase
    end

    // Operand capture and the codeword working register
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            wide_q  <= 1'b0;
            data_q  <= '0;
            noise_q <= '0;
            cw_q    <= '0;
            syn_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            if (start) begin
                op_q    <= CTRL[1:0];
                wide_q  <= CODEWORD_WIDTH[0];
                data_q  <= DATA_IN[DW_W-1:0] & (CODEWORD_WIDTH[0] ? 11'h7FF : 11'h00F);
                noise_q <= NOISE[CW_W-1:0] & cap_mask;
                cw_q    <= DATA_IN[CW_W-1:0] & cap_mask;
            end
            case (state_q)
                S_ENC:   cw_q <= enc_cw;
                S_NOISE: cw_q <= cw_q ^ noise_q;
                S_SYND:  {syn_q, par_q} <= syndrome(cw_q);
                default: ;
            endcase
        end
    end

    // Registered outputs; results load only on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out       <= '0;
            num_of_errors  <= 2'd0;
            operation_done <= 1'b0;
            busy           <= 1'b0;
        end else begin
            operation_done <= (state_d == S_DONE);
            busy           <= (state_d == S_ENC) || (state_d == S_NOISE) ||
                              (state_d == S_SYND) || (state_d == S_CORR);
            if ((state_d == S_DONE) && ((state_q != S_DONE) || start)) begin
                data_out      <= res_d;
                num_of_errors <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_ecc_engine_ctrl.sv
// Scoreboard bench for ecc_engine_ctrl: directed ops push expected results,
// a negedge monitor checks data, error count and done timing.
module tb_ecc_engine_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ctrl, data_in, cw_width, noise;
    logic        ctrl_ready;
    logic [15:0] data_out;
    logic [1:0]  num_of_errors;
    logic        operation_done, busy;

    always #5 clk = ~clk;

    ecc_engine_ctrl #(.AMBA_WORD(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .CTRL           (ctrl),
        .DATA_IN        (data_in),
        .CODEWORD_WIDTH (cw_width),
        .NOISE          (noise),
        .CTRL_ready     (ctrl_ready),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .operation_done (operation_done),
        .busy           (busy)
    );

    typedef struct {
        logic [15:0] data;
        logic [1:0]  err;
        int unsigned cyc;
        int unsigned id;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc    = 0;
    int unsigned vec_id = 0;
    int          n_cmp  = 0;
    int          n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned id, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s (vec %0d): got 0x%0h, required 0x%0h", name, id, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (operation_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: operation_done=1 at cycle %0d, required 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", mon_e.id, cyc, mon_e.cyc);
                chk("data_out", mon_e.id, 32'(data_out), 32'(mon_e.data));
                chk("num_of_errors", mon_e.id, 32'(num_of_errors), 32'(mon_e.err));
            end
        end
    end

    // Drive one op; captured at the next rising edge N, done expected after edge N+lat
    task automatic issue(input logic [15:0] c, input logic [15:0] w, input logic [15:0] d,
                         input logic [15:0] n, input logic [15:0] exp_d, input logic [1:0] exp_e,
                         input int unsigned lat, input bit expect_done);
        exp_t e;
        @(negedge clk);
        ctrl       = c;
        cw_width   = w;
        data_in    = d;
        noise      = n;
        ctrl_ready = 1'b1;
        vec_id++;
        if (expect_done) begin
            e.data = exp_d;
            e.err  = exp_e;
            e.cyc  = cyc + 1 + lat;
            e.id   = vec_id;
            sb.push_back(e);
        end
        @(negedge clk);
        ctrl_ready = 1'b0;
        data_in    = ~d;
        noise      = 16'hFFFF;
        cw_width   = ~w;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
        chk("drain_pending", vec_id, 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        ctrl_ready = 1'b0;
        ctrl       = '0;
        data_in    = '0;
        cw_width   = '0;
        noise      = '0;
        repeat (3) @(negedge clk);
        chk("reset_data_out", 0, 32'(data_out), 32'd0);
        chk("reset_errors", 0, 32'(num_of_errors), 32'd0);
        chk("reset_done", 0, 32'(operation_done), 32'd0);
        chk("reset_busy", 0, 32'(busy), 32'd0);
        reset = 1'b0;

        // encode
        issue(16'd0, 16'd0, 16'h000B, 16'h0000, 16'h00AA, 2'd0, 1, 1'b1); drain();
        issue(16'd0, 16'hFFFE, 16'hFFFB, 16'h0000, 16'h00AA, 2'd0, 1, 1'b1); drain();
        issue(16'd0, 16'd1, 16'h0001, 16'h0000, 16'h000F, 2'd0, 1, 1'b1); drain();
        // decode
        issue(16'd1, 16'd0, 16'h008A, 16'h0000, 16'h000B, 2'd1, 2, 1'b1); drain();
        issue(16'd1, 16'd0, 16'h00AC, 16'h0000, 16'h000B, 2'd2, 2, 1'b1); drain();
        issue(16'd1, 16'd0, 16'h00AA, 16'h0000, 16'h000B, 2'd0, 2, 1'b1); drain();
        // reserved op clears the held result
        issue(16'd3, 16'd0, 16'h00AA, 16'h0000, 16'h0000, 2'd0, 0, 1'b1); drain();
        // full channel
        issue(16'd2, 16'd1, 16'h0000, 16'h0100, 16'h0000, 2'd1, 4, 1'b1); drain();
        issue(16'd2, 16'd1, 16'h0000, 16'h0001, 16'h0000, 2'd1, 4, 1'b1); drain();
        issue(16'd2, 16'd1, 16'h0000, 16'h0006, 16'h0000, 2'd2, 4, 1'b1); drain();
        issue(16'd2, 16'd0, 16'h000B, 16'hFF00, 16'h000B, 2'd0, 4, 1'b1); drain();

        // CTRL_ready during SYND is dropped
        @(negedge clk);
        ctrl = 16'd1; cw_width = 16'd0; data_in = 16'h008A; noise = 16'd0; ctrl_ready = 1'b1;
        vec_id++;
        mon_e.data = 16'h000B; mon_e.err = 2'd1; mon_e.cyc = cyc + 3; mon_e.id = vec_id;
        sb.push_back(mon_e);
        @(negedge clk);
        chk("busy_in_synd", vec_id, 32'(busy), 32'd1);
        ctrl = 16'd0; data_in = 16'h0001;
        @(negedge clk);
        ctrl_ready = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // back-to-back: second op accepted while in DONE
        issue(16'd0, 16'd0, 16'h000B, 16'h0000, 16'h00AA, 2'd0, 1, 1'b1);
        issue(16'd1, 16'd0, 16'h008A, 16'h0000, 16'h000B, 2'd1, 2, 1'b1);
        chk("busy_after_b2b", vec_id, 32'(busy), 32'd1);
        drain();

        // reset during NOISE aborts with no done
        issue(16'd0, 16'd0, 16'h000B, 16'h0000, 16'h00AA, 2'd0, 1, 1'b1); drain();
        issue(16'd2, 16'd1, 16'h0005, 16'h0001, 16'h0000, 2'd0, 4, 1'b0);
        @(negedge clk);
        chk("busy_in_noise", vec_id, 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_data_out", vec_id, 32'(data_out), 32'd0);
        chk("abort_errors", vec_id, 32'(num_of_errors), 32'd0);
        chk("abort_busy", vec_id, 32'(busy), 32'd0);
        chk("abort_done", vec_id, 32'(operation_done), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        issue(16'd0, 16'd0, 16'h000B, 16'h0000, 16'h00AA, 2'd0, 1, 1'b1); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
